alu_issue_stage: RTL and testbench

// - Two-entry pipeline wrapped around the combinational picoMIPS ALU.
// - Registers one operand set (A, B, ctrl) and drives it onto the ALU.
// - Captures the ALU result into an output register.
// - Valid/ready handshake on both sides; sustained throughput is one op per cycle.
// - Upstream: decode/operand fetch. Downstream: register-file writeback.
//

---
 rtl/alu_issue_stage_if.sv | 36 +++
 rtl/alu_issue_stage.sv | 100 ++++++++++
 tb/tb_alu_issue_stage.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_stage_if.sv
// Bundle of the issue-stage signals: upstream operand handshake, the ALU
// side-channel and the downstream result handshake.
//
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both 1. The sender holds valid and its payload steady until that edge.
// A ready may depend combinationally on the other side's ready.
// in_ready follows out_ready within the same cycle.
interface alu_issue_stage_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_A;
  logic [DATA_WIDTH-1:0] in_B;
  logic [2:0]            in_ctrl;
  logic [DATA_WIDTH-1:0] alu_A;
  logic [DATA_WIDTH-1:0] alu_B;
  logic [2:0]            alu_ctrl;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_result;
  logic [2:0]            out_ctrl;

  // Environment view: upstream source, ALU and downstream sink.
  modport master (
    output in_valid, in_A, in_B, in_ctrl, alu_result, out_ready,
    input  in_ready, alu_A, alu_B, alu_ctrl, out_valid, out_result, out_ctrl
  );

  // Issue-stage view.
  modport slave (
    input  in_valid, in_A, in_B, in_ctrl, alu_result, out_ready,
    output in_ready, alu_A, alu_B, alu_ctrl, out_valid, out_result, out_ctrl
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Two-entry pipeline around a combinational ALU.
// Stage 1 holds the operands and drives them onto the ALU. Stage 2 captures the
// ALU result for writeback. With both sides ready it sustains one op per cycle.
module alu_issue_stage #(
  parameter int DATA_WIDTH  = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   nReset,
  input  logic                   flush,
  alu_issue_stage_if.slave       bus,
  output logic [COUNT_WIDTH-1:0] op_count
);

  logic                   r_s1_valid;
  logic [DATA_WIDTH-1:0]  r_s1_a;
  logic [DATA_WIDTH-1:0]  r_s1_b;
  logic [2:0]             r_s1_ctrl;
  logic                   r_out_valid;
  logic [DATA_WIDTH-1:0]  r_out_result;
  logic [2:0]             r_out_ctrl;
  logic [COUNT_WIDTH-1:0] r_op_count;

  logic w_out_fire;
  logic w_s2_free;
  logic w_s1_adv;
  logic w_in_ready;
  logic w_in_fire;

  // The output register can take a new result if it is empty or drains this cycle.
  // Stage 1 can accept if it is empty or is moving forward.
  // There is no skid buffer, so in_ready is combinational through out_ready.
  assign w_out_fire = r_out_valid & bus.out_ready;
  assign w_s2_free  = ~r_out_valid | bus.out_ready;
  assign w_s1_adv   = r_s1_valid & w_s2_free;
  assign w_in_ready = ~r_s1_valid | w_s2_free;
  assign w_in_fire  = bus.in_valid & w_in_ready;

  assign bus.in_ready   = w_in_ready;
  assign bus.alu_A      = r_s1_a;
  assign bus.alu_B      = r_s1_b;
  assign bus.alu_ctrl   = r_s1_ctrl;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_result = r_out_result;
  assign bus.out_ctrl   = r_out_ctrl;
  assign op_count       = r_op_count;

  // Stage occupancy flags; flush empties both stages and discards this cycle's handshakes.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_s1_adv) begin
        r_out_valid <= 1'b1;
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end
      if (w_in_fire) begin
        r_s1_valid <= 1'b1;
      end else if (w_s1_adv) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  // Payload registers; operands and ctrl are passed through untouched.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_s1_a       <= '0;
      r_s1_b       <= '0;
      r_s1_ctrl    <= '0;
      r_out_result <= '0;
      r_out_ctrl   <= '0;
    end else if (!flush) begin
      if (w_in_fire) begin
        r_s1_a    <= bus.in_A;
        r_s1_b    <= bus.in_B;
        r_s1_ctrl <= bus.in_ctrl;
      end
      if (w_s1_adv) begin
        r_out_result <= bus.alu_result;
        r_out_ctrl   <= r_s1_ctrl;
      end
    end
  end

  // Count of completed output handshakes; it wraps silently.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_op_count <= '0;
    end else if (!flush && w_out_fire) begin
      r_op_count <= r_op_count + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage. It models the stage as a capacity-2 in-order queue
// of ops, with one flag saying whether the head is visible at the output.
// A second instance with a 4-bit counter shares the same stimulus.
module tb_alu_issue_stage;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] c;
    logic [7:0] res;
  } op_t;

  logic clk = 1'b0;
  logic nReset = 1'b0;
  logic flush = 1'b0;
  logic [15:0] op_count;
  logic [3:0]  op_count4;

  alu_issue_stage_if #(.DATA_WIDTH(8)) bus ();
  alu_issue_stage_if #(.DATA_WIDTH(8)) bus2 ();

  int n_chk = 0;
  int n_fail = 0;
  int cyc_n = 0;

  op_t        m_q[$];
  bit         m_vis = 1'b0;
  int         m_count = 0;
  logic [7:0] got_q[$];
  logic [2:0] got_c[$];
  int         got_t[$];

  // Reference ALU: A+B for ctrl 000; other codes get simple distinct functions.
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] c);
    case (c)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return b;
    endcase
  endfunction

  alu_issue_stage #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) dut (
    .clk(clk), .nReset(nReset), .flush(flush), .bus(bus), .op_count(op_count)
  );

  alu_issue_stage #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) dut4 (
    .clk(clk), .nReset(nReset), .flush(flush), .bus(bus2), .op_count(op_count4)
  );

  assign bus.alu_result  = alu_f(bus.alu_A, bus.alu_B, bus.alu_ctrl);
  assign bus2.alu_result = alu_f(bus2.alu_A, bus2.alu_B, bus2.alu_ctrl);
  assign bus2.in_valid   = bus.in_valid;
  assign bus2.in_A       = bus.in_A;
  assign bus2.in_B       = bus.in_B;
  assign bus2.in_ctrl    = bus.in_ctrl;
  assign bus2.out_ready  = bus.out_ready;

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // The stage refuses an op only when it holds two and the output is not draining.
  function automatic bit m_in_ready();
    return !(m_q.size() == 2 && !bus.out_ready);
  endfunction

  function automatic bit m_s1_full();
    return (m_q.size() == 2) || (m_q.size() == 1 && !m_vis);
  endfunction

  // behavioural model update
  always @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      m_q.delete();
      m_vis = 1'b0;
      m_count = 0;
    end else begin
      cyc_n++;
      if (flush) begin
        m_q.delete();
        m_vis = 1'b0;
      end else begin
        bit pop;
        bit push;
        op_t op;
        pop  = m_vis && bus.out_ready;
        push = bus.in_valid && m_in_ready();
        if (pop) begin
          void'(m_q.pop_front());
          m_count++;
        end
        if (push) begin
          op.a = bus.in_A; op.b = bus.in_B; op.c = bus.in_ctrl;
          op.res = alu_f(bus.in_A, bus.in_B, bus.in_ctrl);
          m_q.push_back(op);
        end
        if (m_q.size() == 0)               m_vis = 1'b0;
        else if (push && m_q.size() == 1)  m_vis = 1'b0;
        else                               m_vis = 1'b1;
      end
    end
  end

  // monitor of completed output handshakes
  always @(posedge clk) begin
    if (nReset && !flush && bus.out_valid && bus.out_ready) begin
      got_q.push_back(bus.out_result);
      got_c.push_back(bus.out_ctrl);
      got_t.push_back(cyc_n);
    end
  end

  // compare process: checks both DUTs against the model every cycle
  always @(negedge clk) begin
    if (nReset) begin
      chk("in_ready", 32'(bus.in_ready), 32'(m_in_ready()));
      chk("out_valid", 32'(bus.out_valid), 32'(m_vis));
      chk("out_valid_w4", 32'(bus2.out_valid), 32'(m_vis));
      if (m_vis) begin
        chk("out_result", 32'(bus.out_result), 32'(m_q[0].res));
        chk("out_ctrl", 32'(bus.out_ctrl), 32'(m_q[0].c));
      end
      if (m_s1_full()) begin
        chk("alu_A", 32'(bus.alu_A), 32'(m_q[m_q.size()-1].a));
        chk("alu_B", 32'(bus.alu_B), 32'(m_q[m_q.size()-1].b));
        chk("alu_ctrl", 32'(bus.alu_ctrl), 32'(m_q[m_q.size()-1].c));
      end
      chk("op_count", 32'(op_count), 32'(m_count[15:0]));
      chk("op_count_w4", 32'(op_count4), 32'(m_count[3:0]));
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Offer one op until it is accepted; reports how many cycles it waited.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] c, output int waited);
    bit acc;
    acc = 1'b0;
    waited = 0;
    bus.in_valid = 1'b1; bus.in_A = a; bus.in_B = b; bus.in_ctrl = c;
    for (int k = 0; k < 50 && !acc; k++) begin
      #1;
      acc = bus.in_ready;
      if (!acc) waited++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    flush = 1'b0;
    @(posedge clk); #3;
    nReset = 1'b0;
    @(posedge clk); #3;
    nReset = 1'b1;
    @(posedge clk); #1;
    got_q.delete(); got_c.delete(); got_t.delete();
  endtask

  initial begin
    int w;
    bus.in_valid = 1'b0; bus.in_A = '0; bus.in_B = '0; bus.in_ctrl = '0;
    bus.out_ready = 1'b0;
    do_reset();

    // reset state
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_alu_A", 32'(bus.alu_A), 32'd0);
    chk("rst_out_result", 32'(bus.out_result), 32'd0);

    // single op
    bus.out_ready = 1'b1;
    send(8'hF0, 8'h04, 3'd0, w);
    chk("t1_out_valid_edge1", 32'(bus.out_valid), 32'd0);
    chk("t1_alu_A", 32'(bus.alu_A), 32'hF0);
    cyc(1);
    chk("t1_out_valid_edge2", 32'(bus.out_valid), 32'd1);
    chk("t1_out_result", 32'(bus.out_result), 32'hF4);
    chk("t1_out_ctrl", 32'(bus.out_ctrl), 32'd0);
    cyc(1);
    chk("t1_op_count", 32'(op_count), 32'd1);
    chk("t1_got_n", 32'(got_q.size()), 32'd1);

    // back-to-back stream
    do_reset();
    bus.out_ready = 1'b1;
    send(8'd1, 8'd1, 3'd0, w);     chk("t2_stall0", 32'(w), 32'd0);
    send(8'd2, 8'd3, 3'd0, w);     chk("t2_stall1", 32'(w), 32'd0);
    send(8'd127, 8'd1, 3'd0, w);   chk("t2_stall2", 32'(w), 32'd0);
    send(8'h80, 8'hFF, 3'd0, w);   chk("t2_stall3", 32'(w), 32'd0);
    cyc(4);
    chk("t2_got_n", 32'(got_q.size()), 32'd4);
    if (got_q.size() == 4) begin
      chk("t2_r0", 32'(got_q[0]), 32'h02);
      chk("t2_r1", 32'(got_q[1]), 32'h05);
      chk("t2_r2", 32'(got_q[2]), 32'h80);
      chk("t2_r3", 32'(got_q[3]), 32'h7F);
      for (int i = 0; i < 3; i++) chk("t2_consecutive", 32'(got_t[i+1] - got_t[i]), 32'd1);
    end
    chk("t2_op_count", 32'(op_count), 32'd4);

    // backpressure: 2 stored, third refused
    do_reset();
    bus.out_ready = 1'b0;
    send(8'd10, 8'd20, 3'd0, w);
    send(8'd3, 8'd4, 3'd1, w);
    bus.in_valid = 1'b1; bus.in_A = 8'hAA; bus.in_B = 8'h0F; bus.in_ctrl = 3'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t3_in_ready_full", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    send(8'hAA, 8'h0F, 3'd2, w);
    chk("t3_third_immediate", 32'(w), 32'd0);
    cyc(4);
    chk("t3_got_n", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) begin
      chk("t3_r0", 32'(got_q[0]), 32'd30);
      chk("t3_r1", 32'(got_q[1]), 32'hFF);
      chk("t3_c1", 32'(got_c[1]), 32'd1);
      chk("t3_r2", 32'(got_q[2]), 32'h0A);
      chk("t3_c2", 32'(got_c[2]), 32'd2);
    end

    // flush with both stages full
    do_reset();
    bus.out_ready = 1'b0;
    send(8'd1, 8'd2, 3'd0, w);
    send(8'd3, 8'd4, 3'd0, w);
    chk("t4_full_in_ready", 32'(bus.in_ready), 32'd0);
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    chk("t4_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t4_in_ready", 32'(bus.in_ready), 32'd1);
    chk("t4_op_count", 32'(op_count), 32'd0);
    bus.out_ready = 1'b1;
    send(8'd5, 8'd6, 3'd0, w);
    cyc(3);
    chk("t4_got_n", 32'(got_q.size()), 32'd1);
    if (got_q.size() == 1) chk("t4_r0", 32'(got_q[0]), 32'd11);

    // asynchronous reset mid-stream
    do_reset();
    bus.out_ready = 1'b1;
    send(8'd9, 8'd9, 3'd0, w);
    send(8'd7, 8'd7, 3'd4, w);
    cyc(1);
    chk("t5_pre_op_count", 32'(op_count), 32'd1);
    #2;
    nReset = 1'b0;
    #1;
    chk("t5_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_op_count", 32'(op_count), 32'd0);
    chk("t5_out_result", 32'(bus.out_result), 32'd0);
    chk("t5_alu_A", 32'(bus.alu_A), 32'd0);
    chk("t5_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
    @(posedge clk); #3;
    nReset = 1'b1;
    @(posedge clk); #1;
    got_q.delete(); got_c.delete(); got_t.delete();
    send(8'h11, 8'h22, 3'd0, w);
    cyc(3);
    chk("t5_got_n", 32'(got_q.size()), 32'd1);
    if (got_q.size() == 1) chk("t5_r0", 32'(got_q[0]), 32'h33);
    chk("t5_op_count_after", 32'(op_count), 32'd1);

    // counter wrap on the 4-bit instance
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 17; i++) send(8'(i), 8'd1, 3'd0, w);
    cyc(3);
    chk("t6_op_count4_wrap", 32'(op_count4), 32'd1);
    chk("t6_op_count16", 32'(op_count), 32'd17);

    // randomized traffic with backpressure and occasional flush
    do_reset();
    for (int i = 0; i < 800; i++) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.in_A      = 8'($urandom);
      bus.in_B      = 8'($urandom);
      bus.in_ctrl   = 3'($urandom_range(0, 7));
      bus.out_ready = ($urandom_range(0, 9) < 6);
      flush         = ($urandom_range(0, 39) == 0);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    cyc(5);
    chk("rand_drained", 32'(m_q.size()), 32'd0);
    chk("rand_out_valid", 32'(bus.out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
